// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Generic pipeline stage register with a valid/ready handshake and a
//   2-entry skid buffer. The upstream ready comes only from registered
//   state and local controls, so a long combinational ready chain through
//   consecutive stages is avoided. The block also provides stall sources,
//   flush, WFI drain and a saturating stall-cycle counter.
//
//   Ports
//     clk        : clock; all state updates on the rising edge
//     rst        : synchronous reset, active low
//     stall_vec  : per-source stall requests (OR-combined)
//     flush      : invalidate all entries (main/skid <= RST_VAL)
//     wfi        : block intake, keep draining held entries
//     in_valid   : upstream payload valid
//     in_data    : upstream payload
//     in_ready   : stage accepts in_data this cycle
//     out_valid  : out_data valid
//     out_data   : payload presented downstream (main register)
//     out_ready  : downstream accepts out_data
//     occupancy  : entries held (0, 1 or 2)
//     stall_cnt  : saturating count of stalled cycles while holding data
//
//   state   | meaning
//   --------+-----------------------------------------------
//   S_EMPTY | no entry held
//   S_ONE   | one entry, held in r_main
//   S_TWO   | two entries: oldest in r_main, newest in r_skid

module pipe_stage_skid #(
  parameter int                DATA_W    = 64,
  parameter int                NUM_STALL = 2,
  parameter logic [DATA_W-1:0] RST_VAL   = '0,
  parameter int                CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_STALL-1:0] stall_vec,
  input  logic                 flush,
  input  logic                 wfi,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  input  logic                 out_ready,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_stall;
  logic w_in_fire;
  logic w_out_fire;
  logic w_cnt_inc;

  assign w_stall    = |stall_vec;
  assign in_ready   = (r_state != S_TWO) & ~w_stall & ~wfi & ~flush;
  assign out_valid  = (r_state != S_EMPTY) & ~w_stall;
  assign w_in_fire  = in_valid & in_ready;
  // Downstream must ignore out_valid while flush is high; nothing leaves.
  assign w_out_fire = out_valid & out_ready & ~flush;

  assign out_data  = r_main;
  assign stall_cnt = r_stall_cnt;

  // Counts whenever data is held under stall, flush or not; saturates.
  assign w_cnt_inc = w_stall & (r_state != S_EMPTY) & (r_stall_cnt != {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_EMPTY;
      r_main      <= RST_VAL;
      r_skid      <= RST_VAL;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
      if (w_cnt_inc) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = S_EMPTY;
      w_main_nxt  = RST_VAL;
      w_skid_nxt  = RST_VAL;
    end else if (!w_stall) begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = S_ONE;
            w_main_nxt  = in_data;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = in_data;
          end else if (w_in_fire) begin
            w_state_nxt = S_TWO;
            w_skid_nxt  = in_data;
          end else if (w_out_fire) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_TWO: begin
          // in_ready is low here, so only the drain side can move.
          if (w_out_fire) begin
            w_state_nxt = S_ONE;
            w_main_nxt  = r_skid;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  always_comb begin
    occupancy = 2'd0;
    case (r_state)
      S_ONE:   occupancy = 2'd1;
      S_TWO:   occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  logic        clk;
  logic        rst;
  logic [1:0]  stall_vec;
  logic        flush;
  logic        wfi;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  // second instance with a narrow counter for the saturation case
  logic [1:0]  s_stall_vec;
  logic        s_flush;
  logic        s_wfi;
  logic        s_in_valid;
  logic [7:0]  s_in_data;
  logic        s_in_ready;
  logic        s_out_valid;
  logic [7:0]  s_out_data;
  logic        s_out_ready;
  logic [1:0]  s_occupancy;
  logic [3:0]  s_stall_cnt;

  int n_pass;
  int n_total;

  pipe_stage_skid u_dut (
    .clk       (clk),
    .rst       (rst),
    .stall_vec (stall_vec),
    .flush     (flush),
    .wfi       (wfi),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  pipe_stage_skid #(
    .DATA_W  (8),
    .RST_VAL (8'h00),
    .CNT_W   (4)
  ) u_sat (
    .clk       (clk),
    .rst       (rst),
    .stall_vec (s_stall_vec),
    .flush     (s_flush),
    .wfi       (s_wfi),
    .in_valid  (s_in_valid),
    .in_data   (s_in_data),
    .in_ready  (s_in_ready),
    .out_valid (s_out_valid),
    .out_data  (s_out_data),
    .out_ready (s_out_ready),
    .occupancy (s_occupancy),
    .stall_cnt (s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b0; stall_vec = 2'b00; flush = 1'b0; wfi = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    s_stall_vec = 2'b00; s_flush = 1'b0; s_wfi = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;

    // reset
    cyc(2);
    rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_occ",       occupancy, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_in_ready",  in_ready,  1);

    // streaming A, B, C
    out_ready = 1'b1; in_valid = 1'b1; in_data = 64'hA;
    cyc(1);
    check("str_a_data",  out_data,  64'hA);
    check("str_a_valid", out_valid, 1);
    check("str_a_occ",   occupancy, 1);
    in_data = 64'hB;
    cyc(1);
    check("str_b_data",  out_data,  64'hB);
    check("str_b_occ",   occupancy, 1);
    check("str_b_ready", in_ready,  1);
    in_data = 64'hC;
    cyc(1);
    check("str_c_data",  out_data,  64'hC);
    check("str_c_occ",   occupancy, 1);
    in_valid = 1'b0;
    cyc(1);
    check("str_drain_occ", occupancy, 0);

    // backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h1111;
    cyc(1);
    in_data = 64'h2222;
    cyc(1);
    check("bp_occ2",   occupancy, 2);
    check("bp_ready",  in_ready,  0);
    check("bp_data_a", out_data,  64'h1111);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc(1);
    check("bp_occ1",   occupancy, 1);
    check("bp_data_b", out_data,  64'h2222);
    cyc(1);
    check("bp_occ0",   occupancy, 0);

    // stall with one entry held
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hDEAD_BEEF;
    cyc(1);
    in_valid = 1'b0; stall_vec = 2'b10; out_ready = 1'b1;
    #1;
    check("stl_valid", out_valid, 0);
    check("stl_ready", in_ready,  0);
    cyc(5);
    check("stl_cnt",  stall_cnt, 5);
    check("stl_occ",  occupancy, 1);
    check("stl_data", out_data,  64'hDEAD_BEEF);
    stall_vec = 2'b00;
    #1;
    check("stl_rel_valid", out_valid, 1);
    check("stl_rel_data",  out_data,  64'hDEAD_BEEF);
    cyc(1);
    check("stl_rel_occ", occupancy, 0);
    check("stl_cnt_hold", stall_cnt, 5);

    // WFI drain from two entries, intake offered but blocked
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hE;
    cyc(1);
    in_data = 64'hF;
    cyc(1);
    check("wfi_occ2", occupancy, 2);
    wfi = 1'b1; out_ready = 1'b1; in_data = 64'h6;
    #1;
    check("wfi_ready0", in_ready, 0);
    check("wfi_data_e", out_data, 64'hE);
    cyc(1);
    check("wfi_occ1",   occupancy, 1);
    check("wfi_data_f", out_data,  64'hF);
    check("wfi_ready1", in_ready,  0);
    cyc(1);
    check("wfi_occ0",   occupancy, 0);
    check("wfi_ready2", in_ready,  0);
    wfi = 1'b0; in_valid = 1'b0;
    cyc(1);
    check("wfi_no_g", out_valid, 0);

    // flush together with stall while two entries held
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h4848;
    cyc(1);
    in_data = 64'h4949;
    cyc(1);
    check("fl_occ2", occupancy, 2);
    stall_vec = 2'b01; flush = 1'b1; in_valid = 1'b1; in_data = 64'h4A4A; out_ready = 1'b1;
    #1;
    check("fl_ready", in_ready, 0);
    cyc(1);
    check("fl_occ0",  occupancy, 0);
    check("fl_data",  out_data,  0);
    check("fl_cnt",   stall_cnt, 6);
    stall_vec = 2'b00; flush = 1'b0; in_valid = 1'b0;
    cyc(2);
    check("fl_no_j", out_valid, 0);
    check("fl_data2", out_data, 0);

    // reset in the middle of operation
    in_valid = 1'b1; in_data = 64'h5A5A; out_ready = 1'b0;
    cyc(1);
    check("mr_occ1", occupancy, 1);
    in_valid = 1'b0; rst = 1'b0;
    cyc(1);
    rst = 1'b1;
    #1;
    check("mr_occ0",  occupancy, 0);
    check("mr_data",  out_data,  0);
    check("mr_cnt",   stall_cnt, 0);
    check("mr_valid", out_valid, 0);

    // saturation on the narrow counter
    s_in_valid = 1'b1; s_in_data = 8'h77;
    cyc(1);
    s_in_valid = 1'b0; s_stall_vec = 2'b11;
    cyc(14);
    check("sat_14", s_stall_cnt, 14);
    cyc(1);
    check("sat_15", s_stall_cnt, 15);
    cyc(5);
    check("sat_hold", s_stall_cnt, 15);
    check("sat_data", s_out_data, 8'h77);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
